// File: rtl/axi_wresp_pkg.sv
// Shared constants for the AXI write-response generator.
// B FIFO entry layout is {id, user, resp}, with resp in the two LSBs.
package axi_wresp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam int         RESP_W      = 2;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    // A decode miss outranks a beat-count mismatch.
    function automatic logic [1:0] resp_code(input logic decerr, input logic mismatch);
        if (decerr)
            return RESP_DECERR;
        else if (mismatch)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_wresp_fifo.sv
// Synchronous FIFO holding pending B entries; pointers carry one extra wrap bit.
// The head reads as zero while empty so the B outputs idle at 0.
module axi_wresp_fifo
    import axi_wresp_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/axi_write_resp_gen.sv
// Target-side AXI B-channel generator: one AW at a time, counts W beats, queues responses.
// Define AXI_WRESP_ERR_CNT_EN to add the saturating error-response counter err_cnt_o.
// Handshakes: a transfer occurs on a rising clk edge where valid and ready are both 1;
// valid, once raised, is held with stable payload until that edge.
module axi_write_resp_gen
    import axi_wresp_pkg::*;
#(
    parameter int AXI_ID_W   = 16,
    parameter int AXI_USER_W = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ID_W-1:0]   awid_i,
    input  logic [AXI_USER_W-1:0] awuser_i,
    input  logic [LEN_W-1:0]      awlen_i,
    input  logic                  aw_decerr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic                  wvalid_i,
    input  logic                  wlast_i,
    output logic                  wready_o,
    output logic [AXI_ID_W-1:0]   bid_o,
    output logic [1:0]            bresp_o,
    output logic [AXI_USER_W-1:0] buser_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic                  outstanding_o,
    output logic                  full_o
`ifdef AXI_WRESP_ERR_CNT_EN
    ,
    output logic [15:0]           err_cnt_o
`endif
);

    localparam int ENTRY_W = AXI_ID_W + AXI_USER_W + RESP_W;

    state_t                r_state;
    logic                  r_run;
    logic                  r_wready;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_USER_W-1:0] r_user;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_cnt;
    logic                  r_decerr;
    logic                  r_mis;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_close;
    logic                  w_b_hs;
    logic                  w_early;
    logic                  w_late;
    logic                  w_empty;
    logic [1:0]            w_resp;
    logic [ENTRY_W-1:0]    w_din;
    logic [ENTRY_W-1:0]    w_dout;

    // r_run keeps awready low while reset is held.
    assign awready_o     = r_run && (r_state == IDLE) && !full_o;
    assign wready_o      = r_wready;
    assign w_aw_hs       = awvalid_i && awready_o;
    assign w_w_hs        = wvalid_i && r_wready;
    assign w_close       = w_w_hs && wlast_i;
    assign w_b_hs        = bvalid_o && bready_i;
    assign w_early       = wlast_i && (r_cnt < r_len);
    assign w_late        = !wlast_i && (r_cnt == r_len);
    assign w_resp        = resp_code(r_decerr, r_mis || w_early);
    assign w_din         = {r_id, r_user, w_resp};
    assign bvalid_o      = !w_empty;
    assign outstanding_o = (r_state == DATA) || !w_empty;
    assign {bid_o, buser_o, bresp_o} = w_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_run    <= 1'b0;
            r_wready <= 1'b0;
            r_id     <= '0;
            r_user   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_decerr <= 1'b0;
            r_mis    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_aw_hs) begin
                        r_id     <= awid_i;
                        r_user   <= awuser_i;
                        r_len    <= awlen_i;
                        r_decerr <= aw_decerr_i;
                        r_cnt    <= '0;
                        r_mis    <= 1'b0;
                        r_wready <= 1'b1;
                        r_state  <= DATA;
                    end
                end
                DATA: begin
                    if (w_w_hs) begin
                        if (r_cnt != '1)
                            r_cnt <= r_cnt + LEN_W'(1);
                        if (w_early || w_late)
                            r_mis <= 1'b1;
                        if (wlast_i) begin
                            r_wready <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    axi_wresp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_close),
        .din_i   (w_din),
        .pop_i   (w_b_hs),
        .dout_o  (w_dout),
        .full_o  (full_o),
        .empty_o (w_empty)
    );

`ifdef AXI_WRESP_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_err_cnt <= '0;
        else if (w_b_hs && (bresp_o != RESP_OKAY) && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_cnt_o = r_err_cnt;
`endif

endmodule
